// File: rtl/preload_pkg.sv
// Shared sizing helpers for the weight preload path.
package preload_pkg;

   // Number of bits needed to represent value (0 -> 0, 1 -> 1, 3 -> 2, 7 -> 3)
   function automatic int clogb2(input int value);
      int v;
      int r;
      v = value;
      r = 0;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

   // Stream beats needed to fill one weight word
   function automatic int beats_of(input int ww, input int dw);
      return (ww + dw - 1) / dw;
   endfunction

   // Counter width for a counter running 0..n-1, never narrower than one bit
   function automatic int cnt_bits(input int n);
      return (clogb2(n - 1) < 1) ? 1 : clogb2(n - 1);
   endfunction

   localparam int DEF_MAC_NUM = 256;
   localparam int DEF_DW      = 64;
   localparam int DEF_DEPTH   = 4;
   localparam int LANE_BITS   = 5;

endpackage

// File: rtl/preload_word_fifo.sv
// Show-ahead synchronous word FIFO with occupancy count and synchronous flush.
module preload_word_fifo
   import preload_pkg::*;
#(
   parameter int WIDTH = 1280,
   parameter int DEPTH = 4,
   localparam int PW   = clogb2(DEPTH - 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [PW:0]      count,
   output logic [WIDTH-1:0] head
);

   localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop on an empty FIFO is ignored; a push is allowed when not full or when
   // a pop frees a slot in the same cycle.
   always_comb begin
      do_pop  = pop && (count != '0) && !flush;
      do_push = push && ((count != FULL) || do_pop) && !flush;
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Word storage; contents are kept across flush, only the pointers move
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Head is read combinationally so the consumer can sample it while popping
   always_comb head = mem[rd_ptr];

endmodule

// File: rtl/weight_preload_fifo.sv
// Packs AXI-Stream beats into weight words and buffers them for bram_control.
module weight_preload_fifo
   import preload_pkg::*;
#(
   parameter  int MAC_NUM                 = DEF_MAC_NUM,
   parameter  int AXIS_DATA_WIDTH         = DEF_DW,
   parameter  int AXIS_PRELOAD_FIFO_DEPTH = DEF_DEPTH,
   localparam int WW                      = LANE_BITS * MAC_NUM,
   localparam int bit_num                 = clogb2(AXIS_PRELOAD_FIFO_DEPTH - 1)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                       s_axis_tvalid,
   input  logic                       s_axis_tlast,
   output logic                       s_axis_tready,
   input  logic                       preload_flush,
   input  logic                       axis_fifo_read,
   output logic [WW-1:0]              weight_from_preload,
   output logic [bit_num:0]           axis_fifo_cnt,
   output logic                       wait_weight_preload,
   output logic                       underflow_err
);

   localparam int DW    = AXIS_DATA_WIDTH;
   localparam int BEATS = beats_of(WW, DW);
   localparam int BCW   = cnt_bits(BEATS);
   localparam int PW    = BEATS * DW;

   localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BEATS - 1);
   localparam logic [bit_num:0] FULL      = (bit_num + 1)'(AXIS_PRELOAD_FIFO_DEPTH);

   logic [BCW-1:0] beat_cnt;
   logic [WW-1:0]  asm_q;
   logic [WW-1:0]  word_next;
   logic           accept;
   logic           complete;

   // Handshake, word completion and the merged assembly value. Bits above WW on
   // the final beat fall off in the truncating cast; unwritten bits stay zero
   // because the assembly register is cleared after each word.
   always_comb begin
      s_axis_tready = (axis_fifo_cnt != FULL) && !preload_flush;
      accept        = s_axis_tvalid && s_axis_tready;
      complete      = accept && ((beat_cnt == LAST_BEAT) || s_axis_tlast);
      word_next     = asm_q | WW'(PW'(s_axis_tdata) << (int'(beat_cnt) * DW));
   end

   // Packer: beat index and assembly register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_cnt <= '0;
         asm_q    <= '0;
      end else if (preload_flush || complete) begin
         beat_cnt <= '0;
         asm_q    <= '0;
      end else if (accept) begin
         beat_cnt <= beat_cnt + 1'b1;
         asm_q    <= word_next;
      end
   end

   // Sticky underflow flag, cleared only by flush or reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         underflow_err <= 1'b0;
      end else if (preload_flush) begin
         underflow_err <= 1'b0;
      end else if (axis_fifo_read && (axis_fifo_cnt == '0)) begin
         underflow_err <= 1'b1;
      end
   end

   preload_word_fifo #(
      .WIDTH (WW),
      .DEPTH (AXIS_PRELOAD_FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (complete),
      .push_data (word_next),
      .pop       (axis_fifo_read),
      .flush     (preload_flush),
      .count     (axis_fifo_cnt),
      .head      (weight_from_preload)
   );

   // Consumer-side "data available" indication
   always_comb wait_weight_preload = (axis_fifo_cnt != '0);

endmodule

// File: tb/tb_weight_preload_fifo.sv
// Directed bench for weight_preload_fifo at default parameters.
module tb_weight_preload_fifo;

   localparam int WW = 1280;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [63:0]     tdata = '0;
   logic            tvalid = 1'b0;
   logic            tlast = 1'b0;
   logic            tready;
   logic            flush = 1'b0;
   logic            rd = 1'b0;
   logic [WW-1:0]   head;
   logic [2:0]      cnt;
   logic            wait_w;
   logic            uf;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   weight_preload_fifo dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .s_axis_tdata        (tdata),
      .s_axis_tvalid       (tvalid),
      .s_axis_tlast        (tlast),
      .s_axis_tready       (tready),
      .preload_flush       (flush),
      .axis_fifo_read      (rd),
      .weight_from_preload (head),
      .axis_fifo_cnt       (cnt),
      .wait_weight_preload (wait_w),
      .underflow_err       (uf)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wd(input int w, input int i);
      return {32'(w), 32'(i + 1)};
   endfunction

   // One beat, driven at negedge, held until accepted (bounded)
   task automatic beat(input logic [63:0] d, input logic l);
      int n;
      n = 0;
      @(negedge clk);
      tdata  = d;
      tvalid = 1'b1;
      tlast  = l;
      while (!tready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         failures++;
         $error("FAIL beat_timeout observed=tready_low expected=accept");
      end
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
   endtask

   task automatic send_word(input int w, input int nb, input logic last_on_end);
      for (int i = 0; i < nb; i++) beat(wd(w, i), last_on_end && (i == nb - 1));
   endtask

   task automatic pop1();
      @(negedge clk);
      rd = 1'b1;
      @(posedge clk);
      #1;
      rd = 1'b0;
   endtask

   task automatic flush1();
      @(negedge clk);
      flush = 1'b1;
      #1;
      chk("tready_during_flush", 64'(tready), 64'd0);
      @(posedge clk);
      #1;
      flush = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_cnt", 64'(cnt), 64'd0);
      chk("rst_wait", 64'(wait_w), 64'd0);
      chk("rst_uf", 64'(uf), 64'd0);
      chk("rst_head", head[63:0], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_tready", 64'(tready), 64'd1);

      // Full word, tdata 1..20, tlast on beat 20
      for (int i = 0; i < 20; i++) beat(64'(i + 1), i == 19);
      @(negedge clk);
      chk("w1_cnt", 64'(cnt), 64'd1);
      chk("w1_wait", 64'(wait_w), 64'd1);
      chk("w1_lo", head[63:0], 64'h1);
      chk("w1_mid", head[703:640], 64'hB);
      chk("w1_hi", head[1279:1216], 64'h14);
      pop1();
      @(negedge clk);
      chk("w1_pop_cnt", 64'(cnt), 64'd0);

      // Short word terminated by tlast
      beat(64'hA1, 1'b0);
      beat(64'hA2, 1'b0);
      beat(64'hA3, 1'b1);
      beat(64'hB1, 1'b1);
      @(negedge clk);
      chk("short_cnt", 64'(cnt), 64'd2);
      chk("short_b0", head[63:0], 64'hA1);
      chk("short_b1", head[127:64], 64'hA2);
      chk("short_b2", head[191:128], 64'hA3);
      chk("short_zero", 64'(|head[1279:192]), 64'd0);
      pop1();
      @(negedge clk);
      chk("next_b0", head[63:0], 64'hB1);
      chk("next_zero", 64'(|head[1279:64]), 64'd0);
      pop1();
      @(negedge clk);
      chk("short_empty", 64'(cnt), 64'd0);
      chk("no_uf_yet", 64'(uf), 64'd0);

      // Fill to full, stall, pop from full
      for (int w = 1; w <= 4; w++) send_word(w, 20, 1'b0);
      @(negedge clk);
      chk("full_cnt", 64'(cnt), 64'd4);
      chk("full_tready", 64'(tready), 64'd0);
      chk("full_head", head[63:0], wd(1, 0));
      tdata  = wd(5, 0);
      tvalid = 1'b1;
      repeat (2) @(negedge clk);
      chk("stall_cnt", 64'(cnt), 64'd4);
      chk("stall_tready", 64'(tready), 64'd0);
      rd = 1'b1;
      @(posedge clk);
      #1;
      rd = 1'b0;
      @(negedge clk);
      chk("popfull_cnt", 64'(cnt), 64'd3);
      chk("popfull_tready", 64'(tready), 64'd1);
      chk("popfull_head", head[63:0], wd(2, 0));
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      for (int i = 1; i < 20; i++) beat(wd(5, i), 1'b0);
      @(negedge clk);
      chk("w5_cnt", 64'(cnt), 64'd4);
      pop1();
      pop1();
      @(negedge clk);
      chk("two_cnt", 64'(cnt), 64'd2);
      chk("two_head", head[63:0], wd(4, 0));

      // Push and pop on the same edge with cnt = 2
      send_word(6, 19, 1'b0);
      @(negedge clk);
      tdata  = wd(6, 19);
      tvalid = 1'b1;
      rd     = 1'b1;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      rd     = 1'b0;
      @(negedge clk);
      chk("pp_cnt", 64'(cnt), 64'd2);
      chk("pp_head", head[63:0], wd(5, 0));
      chk("pp_head_hi", head[1279:1216], wd(5, 19));

      // Flush mid-word with cnt = 2
      send_word(7, 7, 1'b0);
      flush1();
      @(negedge clk);
      chk("flush_cnt", 64'(cnt), 64'd0);
      chk("flush_wait", 64'(wait_w), 64'd0);
      send_word(8, 20, 1'b0);
      @(negedge clk);
      chk("after_flush_cnt", 64'(cnt), 64'd1);
      chk("after_flush_lo", head[63:0], wd(8, 0));
      chk("after_flush_b7", head[511:448], wd(8, 7));

      // Underflow and its clear
      pop1();
      pop1();
      @(negedge clk);
      chk("uf_set", 64'(uf), 64'd1);
      chk("uf_cnt", 64'(cnt), 64'd0);
      flush1();
      @(negedge clk);
      chk("uf_clear", 64'(uf), 64'd0);

      // Underflowing pop together with a completing push stores the word
      beat(64'hC0, 1'b0);
      @(negedge clk);
      tdata  = 64'hC1;
      tvalid = 1'b1;
      tlast  = 1'b1;
      rd     = 1'b1;
      @(posedge clk);
      #1;
      tvalid = 1'b0;
      tlast  = 1'b0;
      rd     = 1'b0;
      @(negedge clk);
      chk("uf_push_cnt", 64'(cnt), 64'd1);
      chk("uf_push_err", 64'(uf), 64'd1);
      chk("uf_push_b1", head[127:64], 64'hC1);

      // Asynchronous reset in the middle of a transfer
      send_word(9, 3, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_cnt", 64'(cnt), 64'd0);
      chk("arst_wait", 64'(wait_w), 64'd0);
      chk("arst_uf", 64'(uf), 64'd0);
      chk("arst_head", head[127:64], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      beat(64'hD1, 1'b1);
      @(negedge clk);
      chk("arst_next_lo", head[63:0], 64'hD1);
      chk("arst_next_zero", 64'(|head[1279:64]), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
